// File: rtl/priority_decoder_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | priority_decoder_stream: binary index -> one-hot on a valid/ready stream |
// | with a two-entry skid buffer and a sticky seen mask.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module priority_decoder_stream #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_onehot,
  output logic         out_err,
  input  logic         seen_clr,
  output logic [N-1:0] seen_mask
);

  localparam logic [W:0] c_N_EXT = (W+1)'(N);

  logic         w_accept;
  logic         w_xfer;
  logic [W:0]   w_code_ext;
  logic [N-1:0] w_dec_onehot;
  logic         w_dec_err;

  logic         in_ready_q,   in_ready_d;
  logic         out_valid_q,  out_valid_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic         out_err_q,    out_err_d;
  logic         skid_valid_q, skid_valid_d;
  logic [N-1:0] skid_onehot_q, skid_onehot_d;
  logic         skid_err_q,   skid_err_d;
  logic [N-1:0] seen_mask_q,  seen_mask_d;

  assign w_accept = in_valid & in_ready_q;
  assign w_xfer   = out_valid_q & out_ready;

  // Zero-extended compare so codes >= N never alias onto a valid line.
  always_comb begin
    w_code_ext   = {1'b0, in_code};
    w_dec_err    = (w_code_ext >= c_N_EXT);
    w_dec_onehot = '0;
    for (int i = 0; i < N; i++) begin
      w_dec_onehot[i] = (w_code_ext == (W+1)'(i));
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_onehot_d  = out_onehot_q;
    out_err_d     = out_err_q;
    skid_valid_d  = skid_valid_q;
    skid_onehot_d = skid_onehot_q;
    skid_err_d    = skid_err_q;

    // An accept never coincides with a full skid, since in_ready is then low.
    if (w_xfer && skid_valid_q) begin
      out_onehot_d = skid_onehot_q;
      out_err_d    = skid_err_q;
      skid_valid_d = 1'b0;
    end else if (w_accept && (!out_valid_q || w_xfer)) begin
      out_onehot_d = w_dec_onehot;
      out_err_d    = w_dec_err;
      out_valid_d  = 1'b1;
    end else if (w_accept) begin
      skid_onehot_d = w_dec_onehot;
      skid_err_d    = w_dec_err;
      skid_valid_d  = 1'b1;
    end else if (w_xfer) begin
      out_valid_d = 1'b0;
    end

    in_ready_d  = ~skid_valid_d;
    seen_mask_d = (seen_clr ? '0 : seen_mask_q)
                | ((w_accept && !w_dec_err) ? w_dec_onehot : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_onehot_q  <= '0;
      out_err_q     <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_onehot_q <= '0;
      skid_err_q    <= 1'b0;
      seen_mask_q   <= '0;
    end else begin
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_onehot_q  <= out_onehot_d;
      out_err_q     <= out_err_d;
      skid_valid_q  <= skid_valid_d;
      skid_onehot_q <= skid_onehot_d;
      skid_err_q    <= skid_err_d;
      seen_mask_q   <= seen_mask_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_err    = out_err_q;
  assign seen_mask  = seen_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_decoder_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_priority_decoder_stream: bench for N=4 and N=5 decoder instances.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_priority_decoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       seen_clr;
  logic [2:0] code;
  logic       sel5;

  int total = 0;
  int bad   = 0;

  logic       r4, v4, e4;
  logic [3:0] oh4, s4;
  logic       r5, v5, e5;
  logic [4:0] oh5, s5;

  always #5 clk = ~clk;

  priority_decoder_stream #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel5), .in_ready(r4), .in_code(code[1:0]),
    .out_valid(v4), .out_ready(out_ready), .out_onehot(oh4), .out_err(e4),
    .seen_clr(seen_clr), .seen_mask(s4)
  );

  priority_decoder_stream #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel5), .in_ready(r5), .in_code(code),
    .out_valid(v5), .out_ready(out_ready), .out_onehot(oh5), .out_err(e5),
    .seen_clr(seen_clr), .seen_mask(s5)
  );

  // View of whichever instance is currently selected, widened to 5 lines.
  logic       ob_ready, ob_valid, ob_err;
  logic [4:0] ob_onehot, ob_seen;
  assign ob_ready  = sel5 ? r5  : r4;
  assign ob_valid  = sel5 ? v5  : v4;
  assign ob_err    = sel5 ? e5  : e4;
  assign ob_onehot = sel5 ? oh5 : {1'b0, oh4};
  assign ob_seen   = sel5 ? s5  : {1'b0, s4};

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seen_clr = 1'b0; code = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel5 = s[0];
      do_reset();
      total++;
      if ({ob_valid, ob_ready, ob_err, ob_onehot, ob_seen} !== {1'b0, 1'b1, 1'b0, 5'b0, 5'b0}) begin
        bad++;
        $display("FAIL reset_state sel5=%0d got v=%b r=%b e=%b oh=%b seen=%b exp v=0 r=1 e=0 oh=0 seen=0",
                 s, ob_valid, ob_ready, ob_err, ob_onehot, ob_seen);
      end
    end
  endtask

  task automatic test_stream();
    sel5 = 1'b0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; code = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({ob_valid, ob_err, ob_onehot} !== {1'b1, 1'b0, 5'(1 << i)}) begin
        bad++;
        $display("FAIL stream_word%0d got v=%b e=%b oh=%b exp v=1 e=0 oh=%b",
                 i, ob_valid, ob_err, ob_onehot, 5'(1 << i));
      end
      if (i < 3) code = 3'(i + 1);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({ob_valid, ob_seen} !== {1'b0, 5'b01111}) begin
      bad++;
      $display("FAIL stream_end got v=%b seen=%b exp v=0 seen=01111", ob_valid, ob_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_oh [3];
    exp_oh[0] = 5'b00100; exp_oh[1] = 5'b00010; exp_oh[2] = 5'b01000;
    sel5 = 1'b0;
    do_reset();
    in_valid = 1'b1; code = 3'd2;
    @(negedge clk);
    code = 3'd1;
    @(negedge clk);
    total++;
    if ({ob_ready, ob_valid, ob_onehot} !== {1'b0, 1'b1, 5'b00100}) begin
      bad++;
      $display("FAIL bp_full got r=%b v=%b oh=%b exp r=0 v=1 oh=00100", ob_ready, ob_valid, ob_onehot);
    end
    code = 3'd3;
    @(negedge clk);
    total++;
    if ({ob_ready, ob_valid, ob_onehot} !== {1'b0, 1'b1, 5'b00100}) begin
      bad++;
      $display("FAIL bp_stall got r=%b v=%b oh=%b exp r=0 v=1 oh=00100", ob_ready, ob_valid, ob_onehot);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        total++;
        if ({ob_valid, ob_onehot} !== {1'b1, exp_oh[i]}) begin
          bad++;
          $display("FAIL bp_drain%0d got v=%b oh=%b exp v=1 oh=%b", i, ob_valid, ob_onehot, exp_oh[i]);
        end
        if (i == 1) begin
          total++;
          if (ob_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_return got %b exp 1", ob_ready);
          end
        end
        if (i == 2) in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (ob_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty got v=%b exp 0", ob_valid);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] codes [3];
    logic [5:0] expw  [3];
    codes[0] = 3'd6; codes[1] = 3'd4; codes[2] = 3'd7;
    expw[0] = {1'b1, 5'b00000}; expw[1] = {1'b0, 5'b10000}; expw[2] = {1'b1, 5'b00000};
    sel5 = 1'b1;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; code = codes[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ob_valid, ob_err, ob_onehot} !== {1'b1, expw[i]}) begin
        bad++;
        $display("FAIL oor_code%0d got v=%b e=%b oh=%b exp v=1 e=%b oh=%b",
                 codes[i], ob_valid, ob_err, ob_onehot, expw[i][5], expw[i][4:0]);
      end
      if (i < 2) code = codes[i + 1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (ob_seen !== 5'b10000) begin
      bad++;
      $display("FAIL oor_seen got %b exp 10000", ob_seen);
    end
  endtask

  task automatic test_seen_clr();
    sel5 = 1'b0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; code = 3'd0;
    @(negedge clk);
    code = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ob_seen !== 5'b00101) begin
      bad++;
      $display("FAIL seen_pre got %b exp 00101", ob_seen);
    end
    seen_clr = 1'b1; in_valid = 1'b1; code = 3'd1;
    @(negedge clk);
    total++;
    if (ob_seen !== 5'b00010) begin
      bad++;
      $display("FAIL seen_clr_accept got %b exp 00010", ob_seen);
    end
    in_valid = 1'b0;
    @(negedge clk);
    seen_clr = 1'b0;
    total++;
    if (ob_seen !== 5'b00000) begin
      bad++;
      $display("FAIL seen_clr_only got %b exp 00000", ob_seen);
    end
  endtask

  task automatic test_async_reset();
    sel5 = 1'b0;
    do_reset();
    in_valid = 1'b1; code = 3'd0;
    @(negedge clk);
    code = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({ob_ready, ob_valid, ob_seen} !== {1'b0, 1'b1, 5'b00011}) begin
      bad++;
      $display("FAIL arst_fill got r=%b v=%b seen=%b exp r=0 v=1 seen=00011", ob_ready, ob_valid, ob_seen);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ob_ready, ob_valid, ob_onehot, ob_seen} !== {1'b1, 1'b0, 5'b0, 5'b0}) begin
      bad++;
      $display("FAIL arst_immediate got r=%b v=%b oh=%b seen=%b exp r=1 v=0 oh=0 seen=0",
               ob_ready, ob_valid, ob_onehot, ob_seen);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; code = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({ob_valid, ob_onehot} !== {1'b1, 5'b01000}) begin
      bad++;
      $display("FAIL arst_first got v=%b oh=%b exp v=1 oh=01000", ob_valid, ob_onehot);
    end
    @(negedge clk);
    total++;
    if (ob_valid !== 1'b0) begin
      bad++;
      $display("FAIL arst_no_stale got v=%b exp 0", ob_valid);
    end
  endtask

  // Reference: a two-deep FIFO of decoded words; ready while fewer than two held.
  task automatic test_random(input logic use5, input int cycles);
    logic [5:0] q [$];
    logic [4:0] seen_m;
    logic [5:0] w;
    int         n, sz;
    logic       acc;
    int         errs_before;
    sel5 = use5;
    n = use5 ? 5 : 4;
    do_reset();
    seen_m = '0;
    errs_before = bad;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      sz = q.size();
      total++;
      if (ob_ready !== (sz < 2)) begin
        bad++;
        if (bad - errs_before < 10)
          $display("FAIL rnd_in_ready n=%0d cyc=%0d got %b exp %b", n, c, ob_ready, sz < 2);
      end
      total++;
      if (ob_valid !== (sz > 0)) begin
        bad++;
        if (bad - errs_before < 10)
          $display("FAIL rnd_out_valid n=%0d cyc=%0d got %b exp %b", n, c, ob_valid, sz > 0);
      end
      if (sz > 0) begin
        total++;
        if ({ob_err, ob_onehot} !== q[0]) begin
          bad++;
          if (bad - errs_before < 10)
            $display("FAIL rnd_word n=%0d cyc=%0d got e=%b oh=%b exp e=%b oh=%b",
                     n, c, ob_err, ob_onehot, q[0][5], q[0][4:0]);
        end
      end
      total++;
      if (ob_seen !== seen_m) begin
        bad++;
        if (bad - errs_before < 10)
          $display("FAIL rnd_seen n=%0d cyc=%0d got %b exp %b", n, c, ob_seen, seen_m);
      end

      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      seen_clr  = ($urandom_range(0, 31) == 0);
      code      = use5 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));

      acc = in_valid && (sz < 2);
      if (int'(code) < n) w = {1'b0, 5'(1 << code)};
      else w = {1'b1, 5'b0};
      if (out_ready && sz > 0) void'(q.pop_front());
      if (acc) q.push_back(w);
      seen_m = (seen_clr ? 5'b0 : seen_m) | ((acc && !w[5]) ? w[4:0] : 5'b0);
    end
    in_valid = 1'b0; seen_clr = 1'b0;
  endtask

  initial begin
    sel5 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_out_of_range();
    test_seen_clr();
    test_async_reset();
    test_random(1'b0, 10000);
    test_random(1'b1, 10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
